// File: rtl/bias_load_ctrl_if.sv
// rtl/bias_load_ctrl_if.sv - memory read port, bias buffer port and compute-engine handshake
interface bias_load_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [63:0]       mem_rdata;
    logic              buf_readen;
    logic [6:0]        buf_in_index;
    logic [63:0]       buf_datain;
    logic [6:0]        buf_out_index;
    logic              bias_next;
    logic              bias_valid;

    modport master (
        output mem_req, mem_addr, buf_readen, buf_in_index, buf_datain,
               buf_out_index, bias_valid,
        input  mem_valid, mem_rdata, bias_next
    );

    modport slave (
        input  mem_req, mem_addr, buf_readen, buf_in_index, buf_datain,
               buf_out_index, bias_valid,
        output mem_valid, mem_rdata, bias_next
    );
endinterface

// File: rtl/bias_load_ctrl.sv
// rtl/bias_load_ctrl.sv - fetches a layer's biases into the bias buffer, then serves them per channel
module bias_load_ctrl #(
    parameter int MAX_CH = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        num_ch,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    bias_load_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WRITE, S_PRIME, S_SERVE, S_DONE
    } state_t;

    localparam logic [7:0] MAX_CH_W = 8'(MAX_CH);

    state_t            state, state_nx;
    logic [6:0]        n_in;
    logic [6:0]        n_q;
    logic [6:0]        n_m1;
    logic [6:0]        last_beat;
    logic [6:0]        b_q;
    logic [6:0]        c_q;
    logic              bv_q;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;
    logic [6:0]        in_idx_q;
    logic [63:0]       datain_q;
    logic [6:0]        out_idx_q;

    always_comb begin
        if ({1'b0, num_ch} > MAX_CH_W) n_in = MAX_CH_W[6:0];
        else                           n_in = num_ch;
    end

    // beats-1 == (n-1)>>2 for n >= 1, so no extra adder is needed
    assign n_m1      = n_q - 7'd1;
    assign last_beat = {2'b00, n_m1[6:2]};

    assign bus.mem_req       = (state == S_FETCH);
    assign bus.mem_addr      = addr_q;
    assign bus.buf_readen    = (state == S_WRITE);
    assign bus.buf_in_index  = in_idx_q;
    assign bus.buf_datain    = datain_q;
    assign bus.buf_out_index = out_idx_q;
    assign bus.bias_valid    = (state == S_SERVE) && bv_q;
    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);
    assign accept            = bus.bias_valid && bus.bias_next;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = (n_in == 7'd0) ? S_DONE : S_FETCH;
            S_FETCH: if (bus.mem_valid) state_nx = S_WRITE;
            S_WRITE: state_nx = (b_q == last_beat) ? S_PRIME : S_FETCH;
            S_PRIME: state_nx = S_SERVE;
            S_SERVE: if (accept && (c_q == n_m1)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            n_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            bv_q      <= 1'b0;
            addr_q    <= '0;
            in_idx_q  <= '0;
            datain_q  <= '0;
            out_idx_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (n_in != 7'd0)) begin
                        n_q       <= n_in;
                        addr_q    <= base_addr;
                        b_q       <= '0;
                        c_q       <= '0;
                        out_idx_q <= '0;
                        bv_q      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_valid) begin
                        datain_q <= bus.mem_rdata;
                        in_idx_q <= b_q;
                    end
                end
                S_WRITE: begin
                    if (b_q != last_beat) begin
                        b_q    <= b_q + 7'd1;
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                // index 0 was set at start; the buffer registers it this cycle
                S_PRIME: bv_q <= 1'b1;
                S_SERVE: begin
                    if (accept) begin
                        bv_q <= 1'b0;
                        if (c_q != n_m1) begin
                            c_q       <= c_q + 7'd1;
                            out_idx_q <= out_idx_q + 7'd1;
                        end
                    end else if (!bv_q) begin
                        bv_q <= 1'b1;
                    end
                end
                default: bv_q <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_bias_load_ctrl.sv
// tb/tb_bias_load_ctrl.sv - directed scoreboard bench for bias_load_ctrl
module tb_bias_load_ctrl;
    localparam int MAX_CH = 8;
    localparam int ADDR_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  num_ch = '0;
    logic [15:0] base_addr = '0;
    logic        busy;
    logic        done;

    bias_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    bias_load_ctrl #(.MAX_CH(MAX_CH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_ch    (num_ch),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word(input logic [15:0] a);
        return {a[13:0], 2'd3, a[13:0], 2'd2, a[13:0], 2'd1, a[13:0], 2'd0};
    endfunction

    function automatic logic [15:0] bias_of(input logic [15:0] base, input int ch);
        logic [15:0] a;
        a = base + 16'(ch >> 2);
        return {a[13:0], 2'(ch & 3)};
    endfunction

    logic [15:0] exp_addr[$];
    logic [6:0]  exp_widx[$];
    logic [63:0] exp_wdata[$];
    int          exp_ch[$];
    logic [15:0] cur_base = '0;

    // bias buffer model with registered read port
    logic [15:0] bmem [0:MAX_CH-1];
    logic [15:0] bdout;
    always @(posedge clk) begin
        if (bus.buf_readen)
            for (int k = 0; k < 4; k++)
                if (4 * int'(bus.buf_in_index) + k < MAX_CH)
                    bmem[4 * int'(bus.buf_in_index) + k] <= bus.buf_datain[16*k +: 16];
        if (int'(bus.buf_out_index) < MAX_CH) bdout <= bmem[bus.buf_out_index];
        else                                  bdout <= 16'hxxxx;
    end

    // memory responder: answers mem_valid mem_lat cycles after the request appears
    int   mem_lat = 1;
    int   rcnt    = 0;
    logic resp    = 1'b0;
    logic inject  = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (!rst || resp) begin
            resp = 1'b0;
            rcnt = 0;
        end else if (bus.mem_req) begin
            if (rcnt >= mem_lat) begin
                resp = 1'b1;
                bus.mem_rdata = word(bus.mem_addr);
            end else begin
                rcnt++;
            end
        end
        bus.mem_valid = resp | inject;
    end

    logic        prev_req  = 1'b0;
    logic [15:0] prev_addr = '0;
    logic        prev_bv   = 1'b0;
    logic        prime_chk = 1'b0;
    logic        held_mode = 1'b0;
    int          wr_cyc    = 0;
    int          last_acc  = -100;
    int          done_cnt  = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_req  = 1'b0;
            prev_bv   = 1'b0;
            prime_chk = 1'b0;
        end else begin
            if (bus.mem_req) begin
                if (!prev_req) begin
                    chk("req_expected", 64'(exp_addr.size() > 0), 64'd1);
                    if (exp_addr.size() > 0) chk("req_addr", 64'(bus.mem_addr), 64'(exp_addr.pop_front()));
                end else begin
                    chk("addr_stable", 64'(bus.mem_addr), 64'(prev_addr));
                end
            end
            if (bus.buf_readen) begin
                chk("write_expected", 64'(exp_widx.size() > 0), 64'd1);
                if (exp_widx.size() > 0) begin
                    chk("wr_idx", 64'(bus.buf_in_index), 64'(exp_widx.pop_front()));
                    chk("wr_data", bus.buf_datain, exp_wdata.pop_front());
                end
                wr_cyc    = cyc;
                prime_chk = 1'b1;
            end
            if (bus.bias_valid && !prev_bv && prime_chk) begin
                chk("prime_latency", 64'(cyc - wr_cyc), 64'd2);
                prime_chk = 1'b0;
            end
            if (bus.bias_valid) begin
                chk("bias_expected", 64'(exp_ch.size() > 0), 64'd1);
                if (exp_ch.size() > 0) begin
                    chk("out_idx", 64'(bus.buf_out_index), 64'(exp_ch[0]));
                    chk("bias_val", 64'(bdout), 64'(bias_of(cur_base, exp_ch[0])));
                    if (bus.bias_next) begin
                        if (held_mode && last_acc >= 0) chk("accept_spacing", 64'(cyc - last_acc), 64'd2);
                        last_acc = cyc;
                        void'(exp_ch.pop_front());
                    end
                end
            end
            if (done) done_cnt++;
            prev_req  = bus.mem_req;
            prev_addr = bus.mem_addr;
            prev_bv   = bus.bias_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 64'(bus.mem_req), 64'd0);
        chk({tag, "_buf_readen"}, 64'(bus.buf_readen), 64'd0);
        chk({tag, "_bias_valid"}, 64'(bus.bias_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        chk({tag, "_in_index"}, 64'(bus.buf_in_index), 64'd0);
        chk({tag, "_datain"}, bus.buf_datain, 64'd0);
        chk({tag, "_out_index"}, 64'(bus.buf_out_index), 64'd0);
    endtask

    task automatic load(input int n_raw, input logic [15:0] base, input int lat);
        int n;
        n = (n_raw > MAX_CH) ? MAX_CH : n_raw;
        mem_lat  = lat;
        cur_base = base;
        last_acc = -100;
        for (int b = 0; b < (n + 3) / 4; b++) begin
            exp_addr.push_back(base + 16'(b));
            exp_widx.push_back(7'(b));
            exp_wdata.push_back(word(base + 16'(b)));
        end
        for (int c = 0; c < n; c++) exp_ch.push_back(c);
        start     = 1'b1;
        num_ch    = 7'(n_raw);
        base_addr = base;
        step();
        start = 1'b0;
        if (n > 0) begin
            chk("req_after_start", 64'(bus.mem_req), 64'd1);
        end else begin
            chk("zero_done", 64'(done), 64'd1);
            chk("zero_no_req", 64'(bus.mem_req), 64'd0);
        end
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.bias_valid && k < 300) begin
            step();
            k++;
        end
        chk("wait_valid", 64'(bus.bias_valid), 64'd1);
    endtask

    task automatic serve(input int n, input bit held, input int gap);
        if (held) begin
            int k = 0;
            wait_valid();
            held_mode     = 1'b1;
            bus.bias_next = 1'b1;
            while (!done && k < 300) begin
                step();
                k++;
            end
            bus.bias_next = 1'b0;
            held_mode     = 1'b0;
            chk("held_done", 64'(done), 64'd1);
        end else begin
            for (int i = 0; i < n; i++) begin
                wait_valid();
                bus.bias_next = 1'b1;
                step();
                bus.bias_next = 1'b0;
                if (i < n - 1) begin
                    chk("valid_drop", 64'(bus.bias_valid), 64'd0);
                    if (gap == 0) begin
                        step();
                        chk("valid_back", 64'(bus.bias_valid), 64'd1);
                    end
                    repeat (gap) step();
                end else begin
                    chk("done_pulse", 64'(done), 64'd1);
                end
            end
        end
        step();
        chk("busy_clear", 64'(busy), 64'd0);
        chk("done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int saved;
        bus.bias_next = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b1;
        step();

        load(8, 16'h0100, 1);
        serve(8, 1'b0, 0);

        load(5, 16'hFFFF, 3);
        serve(5, 1'b0, 2);

        load(6, 16'h2000, 0);
        serve(6, 1'b1, 0);

        load(0, 16'h3000, 1);
        step();
        chk("zero_busy_after", 64'(busy), 64'd0);
        chk("zero_done_after", 64'(done), 64'd0);

        load(20, 16'h0400, 1);
        serve(8, 1'b0, 0);

        load(4, 16'h0500, 4);
        step();
        start = 1'b1; num_ch = 7'd2; base_addr = 16'h0777;
        step();
        start = 1'b0;
        chk("start_ignored_busy", 64'(busy), 64'd1);
        chk("start_ignored_addr", 64'(bus.mem_addr), 64'h0500);
        wait_valid();
        inject = 1'b1;
        step();
        inject = 1'b0;
        chk("spurious_valid_hold", 64'(bus.bias_valid), 64'd1);
        chk("spurious_no_req", 64'(bus.mem_req), 64'd0);
        serve(4, 1'b0, 0);

        load(8, 16'h0600, 10);
        step();
        step();
        chk("abort_req_high", 64'(bus.mem_req), 64'd1);
        saved = done_cnt;
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_addr.delete();
        exp_widx.delete();
        exp_wdata.delete();
        exp_ch.delete();
        check_reset_outputs("abort");
        repeat (3) step();
        chk("abort_no_done", 64'(done_cnt), 64'(saved));

        load(3, 16'h0700, 1);
        serve(3, 1'b0, 0);

        repeat (3) step();
        chk("queues_empty", 64'(exp_addr.size() + exp_widx.size() + exp_ch.size()), 64'd0);
        chk("done_total", 64'(done_cnt), 64'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bias_load_ctrl.md
# bias_load_ctrl

Sequencer for the bias buffer of the CNN accelerator. On a layer start it fetches the layer's 16-bit biases from external memory as 64-bit beats (4 biases per beat), writes each beat into the bias buffer, then serves biases one output channel at a time to the compute engine. Sits between the layer controller, the external memory port and the bias buffer.

## Interface
- MAX_CH, 8: bias buffer depth in entries; multiple of 4, ≤ 128; the bias buffer must hold ≥ MAX_CH entries
- ADDR_W, 16: external memory word-address width (one word = 64 bits)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a load; honoured only in IDLE
- num_ch  in  7  output channels this layer; sampled on start; values > MAX_CH clamp to MAX_CH
- base_addr  in  ADDR_W  word address of first bias beat; sampled on start
- mem_req  out  1  read request, held until mem_valid
- mem_addr  out  ADDR_W  read word address, stable while mem_req
- mem_valid  in  1  read data valid; one cycle per request
- mem_rdata  in  64  read data, bias k+0 in [15:0] … k+3 in [63:48]
- buf_readen  out  1  bias buffer write strobe
- buf_in_index  out  7  beat index for the write (entries 4*idx..4*idx+3)
- buf_datain  out  64  beat data for the write
- buf_out_index  out  7  bias buffer read index
- bias_next  in  1  compute engine consumed current bias
- bias_valid  out  1  bias buffer dataout holds bias for the current channel
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last channel is consumed

## Operation
- States: IDLE, FETCH, WRITE, PRIME, SERVE, DONE.
- Beats = (n+3)>>2, n = clamped num_ch; beat counter b, channel counter c.
- IDLE: start with n=0 → DONE; start with n>0 → latch n and base_addr, b=0, c=0, buf_out_index=0 → FETCH.
- FETCH: mem_req=1, mem_addr=base_addr+b. On mem_valid: register mem_rdata into buf_datain, buf_in_index=b → WRITE; mem_req low from next cycle.
- WRITE: buf_readen=1 for exactly one cycle. If b = beats-1 → PRIME, else b+1 → FETCH.
- PRIME: one cycle, buf_out_index=0 presented to buffer → SERVE.
- SERVE: bias_valid high when buffer dataout reflects buf_out_index. bias_next while bias_valid: if c = n-1 → DONE; else c+1, buf_out_index+1, bias_valid low one cycle.
- DONE: done=1 one cycle → IDLE.
- Ignored: start outside IDLE; mem_valid outside FETCH; bias_next outside SERVE or while bias_valid low.
- Address arithmetic wraps modulo 2^ADDR_W; counters never exceed beats-1 / n-1.
- Final beat of a non-multiple-of-4 n writes its unused lanes too; they are never read.

## Timing
- Reset (rst=0 at an edge): state IDLE; mem_req, buf_readen, bias_valid, busy, done = 0; mem_addr, buf_in_index, buf_datain, buf_out_index = 0; counters 0. Reset mid-load or mid-serve aborts with no done pulse.
- start at t → mem_req=1 at t+1.
- mem_valid at u → buf_readen=1 at u+1; next mem_req at u+2 (≥2 cycles between requests).
- Last WRITE at w → PRIME at w+1 → bias_valid=1 at w+2.
- bias_next at s (non-last) → buf_out_index new at s+1, bias_valid=0 at s+1, bias_valid=1 at s+2 (buffer output registered). Peak rate one bias per 2 cycles.
- Last bias_next at s → done=1 at s+1, busy=0 at s+2; start accepted from s+2.
- n=0: start at t → done=1 at t+1, no memory traffic.

## Test plan
- n=8, base_addr=0x0100, mem_valid 1 cycle after each req → addrs 0x0100, 0x0101; buf_readen at idx 0,1 with captured data; bias_valid 2 cycles after last write.
- n=5, mem_valid delayed 3 cycles → 2 beats fetched, mem_addr stable while waiting; five bias_next pulses step buf_out_index 0..4; done after 5th.
- bias_next held high every cycle in SERVE → accepted only on valid cycles; channel advances every 2 cycles; done at c=n-1.
- n=0 and n=20 (MAX_CH=8) → n=0: done at t+1, mem_req never high; n=20: exactly 2 beats, 8 channels served.
- start and spurious mem_valid during FETCH/SERVE → no state change, no extra requests.
- rst low during FETCH with mem_req high → next cycle all outputs reset values, IDLE; fresh start completes normally.
